pe_mem_reader: RTL and testbench



---
 rtl/pe_mem_reader.sv | 156 +++++++++++++++
 tb/tb_pe_mem_reader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_mem_reader.sv
// Read sequencer for one PE memory: sweeps word addresses 0..DEPTH-1, forwards
// each word with its index, then optionally reads back the whole frame.
module pe_mem_reader #(
  parameter int WIDTH            = 8,
  parameter int DEPTH            = 3,
  parameter int ADDR_WIDTH       = 8,
  parameter int DATA_FRAME_WIDTH = WIDTH * DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_valid,
  output logic                        start_ready,
  input  logic                        start_frame,
  output logic                        addr_valid,
  input  logic                        addr_ready,
  output logic [ADDR_WIDTH-1:0]       addr,
  input  logic                        rdata_valid,
  output logic                        rdata_ready,
  input  logic [WIDTH-1:0]            rdata,
  input  logic                        frame_valid,
  output logic                        frame_ready,
  input  logic [DATA_FRAME_WIDTH-1:0] frame,
  output logic                        word_valid,
  input  logic                        word_ready,
  output logic [WIDTH-1:0]            word,
  output logic [ADDR_WIDTH-1:0]       word_idx,
  output logic                        word_last,
  output logic                        fout_valid,
  input  logic                        fout_ready,
  output logic [DATA_FRAME_WIDTH-1:0] fout,
  output logic                        busy
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT_D,
    EMIT,
    F_ADDR,
    WAIT_F,
    F_EMIT
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] FRAME_ADDR = '1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  frame_flag;

  // Every handshake output is a register set on the transition into the state
  // that owns it, so no ready ever depends combinationally on a valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      frame_flag  <= 1'b0;
      start_ready <= 1'b1;
      addr_valid  <= 1'b0;
      addr        <= '0;
      rdata_ready <= 1'b0;
      frame_ready <= 1'b0;
      word_valid  <= 1'b0;
      word        <= '0;
      word_idx    <= '0;
      word_last   <= 1'b0;
      fout_valid  <= 1'b0;
      fout        <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid && start_ready) begin
            frame_flag  <= start_frame;
            idx         <= '0;
            start_ready <= 1'b0;
            busy        <= 1'b1;
            addr_valid  <= 1'b1;
            addr        <= '0;
            state       <= ADDR;
          end
        end
        ADDR: begin
          if (addr_ready) begin
            addr_valid  <= 1'b0;
            rdata_ready <= 1'b1;
            state       <= WAIT_D;
          end
        end
        WAIT_D: begin
          if (rdata_valid) begin
            word        <= rdata;
            word_idx    <= idx;
            word_last   <= (idx == LAST_IDX);
            rdata_ready <= 1'b0;
            word_valid  <= 1'b1;
            state       <= EMIT;
          end
        end
        EMIT: begin
          if (word_ready) begin
            word_valid <= 1'b0;
            if (idx < LAST_IDX) begin
              idx        <= idx + 1'b1;
              addr       <= idx + 1'b1;
              addr_valid <= 1'b1;
              state      <= ADDR;
            end else if (frame_flag) begin
              addr       <= FRAME_ADDR;
              addr_valid <= 1'b1;
              state      <= F_ADDR;
            end else begin
              start_ready <= 1'b1;
              busy        <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        F_ADDR: begin
          if (addr_ready) begin
            addr_valid  <= 1'b0;
            frame_ready <= 1'b1;
            state       <= WAIT_F;
          end
        end
        WAIT_F: begin
          if (frame_valid) begin
            fout        <= frame;
            frame_ready <= 1'b0;
            fout_valid  <= 1'b1;
            state       <= F_EMIT;
          end
        end
        F_EMIT: begin
          if (fout_ready) begin
            fout_valid  <= 1'b0;
            start_ready <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          start_ready <= 1'b1;
          addr_valid  <= 1'b0;
          rdata_ready <= 1'b0;
          frame_ready <= 1'b0;
          word_valid  <= 1'b0;
          fout_valid  <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_mem_reader.sv
// Directed bench for pe_mem_reader with a one-request memory responder and
// transfer monitors feeding hand-computed expectations.
module tb_pe_mem_reader;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam int AW    = 8;
  localparam int FW    = WIDTH * DEPTH;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_valid, start_ready, start_frame;
  logic          addr_valid, addr_ready;
  logic [AW-1:0] addr;
  logic          rdata_valid, rdata_ready;
  logic [7:0]    rdata;
  logic          frame_valid, frame_ready;
  logic [FW-1:0] frame;
  logic          word_valid, word_ready, word_last;
  logic [7:0]    word;
  logic [AW-1:0] word_idx;
  logic          fout_valid, fout_ready;
  logic [FW-1:0] fout;
  logic          busy;

  logic [FW-1:0] mem_frame = 24'h332211;
  logic          ar, inj;
  logic          m_rv, m_fv;
  logic [7:0]    m_rd;
  logic [FW-1:0] m_fr;

  int checks = 0;
  int failures = 0;

  logic [AW-1:0] aq[$];
  logic [16:0]   wq[$];
  logic [FW-1:0] fq[$];

  always #5 clk = ~clk;

  assign addr_ready  = ar;
  assign rdata_valid = m_rv | inj;
  assign rdata       = inj ? 8'h55 : m_rd;
  assign frame_valid = m_fv;
  assign frame       = m_fr;

  pe_mem_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready), .start_frame(start_frame),
    .addr_valid(addr_valid), .addr_ready(addr_ready), .addr(addr),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame(frame),
    .word_valid(word_valid), .word_ready(word_ready), .word(word),
    .word_idx(word_idx), .word_last(word_last),
    .fout_valid(fout_valid), .fout_ready(fout_ready), .fout(fout),
    .busy(busy)
  );

  // Memory: answers an accepted address on the following cycle, holds until taken.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rv <= 1'b0;
      m_fv <= 1'b0;
      m_rd <= '0;
      m_fr <= '0;
    end else begin
      if (m_rv && rdata_ready) m_rv <= 1'b0;
      if (m_fv && frame_ready) m_fv <= 1'b0;
      if (addr_valid && addr_ready) begin
        if (addr == 8'hFF) begin
          m_fv <= 1'b1;
          m_fr <= mem_frame;
        end else begin
          m_rv <= 1'b1;
          m_rd <= mem_frame[8*addr +: 8];
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (addr_valid && addr_ready) aq.push_back(addr);
      if (word_valid && word_ready) wq.push_back({word_last, word_idx, word});
      if (fout_valid && fout_ready) fq.push_back(fout);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    aq.delete();
    wq.delete();
    fq.delete();
  endtask

  task automatic do_start(input logic fr);
    @(negedge clk);
    start_valid = 1'b1;
    start_frame = fr;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
  endtask

  // Counts edges after the start edge until busy falls.
  task automatic wait_idle(input string tag, output int cycles);
    cycles = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      cycles++;
      #1;
      if (!busy) break;
    end
    if (busy) check_val({tag, "_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic check_words(input string tag);
    check_val({tag, "_wcount"}, 32'(wq.size()), 32'd3);
    for (int i = 0; i < 3 && i < wq.size(); i++)
      check_val({tag, "_word"}, 32'(wq[i]),
                32'({(i == 2) ? 1'b1 : 1'b0, 8'(i), 8'(8'h11 * (i + 1))}));
  endtask

  initial begin
    int  cyc;
    int  na;
    logic ok;

    rst_n = 1'b0; start_valid = 1'b0; start_frame = 1'b0;
    ar = 1'b1; inj = 1'b0; word_ready = 1'b1; fout_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check_val("rst_start_ready", 32'(start_ready), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_valids", 32'({addr_valid, word_valid, fout_valid, rdata_ready, frame_ready}), 32'd0);
    check_val("rst_addr", 32'(addr), 32'd0);

    // Plain sweep
    clear_q();
    do_start(1'b0);
    wait_idle("sweep0", cyc);
    check_val("sweep0_cycles", 32'(cyc), 32'd9);
    check_val("sweep0_acount", 32'(aq.size()), 32'd3);
    for (int i = 0; i < 3 && i < aq.size(); i++)
      check_val("sweep0_addr", 32'(aq[i]), 32'(i));
    check_words("sweep0");
    check_val("sweep0_fcount", 32'(fq.size()), 32'd0);

    // Sweep with frame readback
    clear_q();
    do_start(1'b1);
    wait_idle("sweep1", cyc);
    check_val("sweep1_cycles", 32'(cyc), 32'd12);
    check_val("sweep1_acount", 32'(aq.size()), 32'd4);
    if (aq.size() == 4) check_val("sweep1_faddr", 32'(aq[3]), 32'hFF);
    check_words("sweep1");
    check_val("sweep1_fcount", 32'(fq.size()), 32'd1);
    if (fq.size() > 0) check_val("sweep1_fout", 32'(fq[0]), 32'h332211);

    // Backpressure on address then on word idx 1
    clear_q();
    ar = 1'b0;
    do_start(1'b0);
    ok = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (!(addr_valid && addr == 8'd0)) ok = 1'b0;
    end
    check_val("bp_addr_hold", 32'(ok), 32'd1);
    check_val("bp_addr_none", 32'(aq.size()), 32'd0);
    ar = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (word_valid && word_idx == 8'd1) begin
        ok = 1'b1;
        break;
      end
    end
    word_ready = 1'b0;
    check_val("bp_reach_idx1", 32'(ok), 32'd1);
    na = aq.size();
    ok = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (!(word_valid && word == 8'h22 && !addr_valid)) ok = 1'b0;
    end
    check_val("bp_word_hold", 32'(ok), 32'd1);
    check_val("bp_no_new_addr", 32'(aq.size()), 32'(na));
    word_ready = 1'b1;
    wait_idle("bp", cyc);
    check_words("bp");

    // Asynchronous reset in WAIT_D for idx 1
    clear_q();
    do_start(1'b0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (rdata_ready && aq.size() == 2) begin
        ok = 1'b1;
        break;
      end
    end
    check_val("ar_reach_waitd", 32'(ok), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("ar_start_ready", 32'(start_ready), 32'd1);
    check_val("ar_busy", 32'(busy), 32'd0);
    check_val("ar_valids", 32'({addr_valid, word_valid, fout_valid, rdata_ready, frame_ready}), 32'd0);
    check_val("ar_data", 32'({addr, word, word_idx, word_last}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_q();
    do_start(1'b0);
    wait_idle("ar_resweep", cyc);
    check_val("ar_resweep_cycles", 32'(cyc), 32'd9);
    if (aq.size() > 0) check_val("ar_resweep_addr0", 32'(aq[0]), 32'd0);
    check_words("ar_resweep");

    // Stray rdata_valid during frame readback
    clear_q();
    do_start(1'b1);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (addr_valid && addr == 8'hFF) begin
        ok = 1'b1;
        break;
      end
    end
    check_val("inj_reach_faddr", 32'(ok), 32'd1);
    inj = 1'b1;
    ar = 1'b0;
    ok = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (rdata_ready || word_valid) ok = 1'b0;
    end
    ar = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (rdata_ready || word_valid) ok = 1'b0;
      if (!busy) break;
    end
    check_val("inj_not_taken", 32'(ok), 32'd1);
    check_val("inj_idle", 32'(busy), 32'd0);
    check_val("inj_wcount", 32'(wq.size()), 32'd3);
    check_val("inj_fcount", 32'(fq.size()), 32'd1);
    if (fq.size() > 0) check_val("inj_fout", 32'(fq[0]), 32'h332211);
    inj = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
